// File: rtl/fifo_wr_ctrl_pkg.sv
// rtl/fifo_wr_ctrl_pkg.sv - shared FIFO pointer helpers (Gray coding, pointer width)
package fifo_pkg;

    localparam int GW = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Width-generic: callers zero-extend to GW bits and cast the result back down.
    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - producer, memory and pointer-exchange signals of the FIFO write side
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in;
    logic [NUM_REQ-1:0]            gnt;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [ADDR_WIDTH:0]           wptr_gray;
    logic [ADDR_WIDTH:0]           rptr_sync;
    logic                          full;
    logic                          almost_full;
    logic [ADDR_WIDTH:0]           wlevel;

    modport master (
        output req, wdata_in, rptr_sync,
        input  gnt, mem_we, mem_waddr, mem_wdata, wptr_gray, full, almost_full, wlevel
    );

    modport slave (
        input  req, wdata_in, rptr_sync,
        output gnt, mem_we, mem_waddr, mem_wdata, wptr_gray, full, almost_full, wlevel
    );
endinterface

// File: rtl/fifo_wr_ctrl_rr_arbiter.sv
// rtl/fifo_wr_ctrl_rr_arbiter.sv - combinational round-robin arbiter, search starts at rr
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(rr) + k) % N;
            if (en && !found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write side: producer arbitration, write pointers, full/level flags
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int AF_THRESH  = 56
) (
    input logic          clk,
    input logic          rst,
    fifo_wr_ctrl_if.slave bus
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] wptr_bin, wptr_gray_q, wlevel_q;
    logic [PTR_W-1:0] next_bin, next_gray, rptr_bin, full_cmp, level_next;
    logic             full_q, af_q;
    logic [IW-1:0]    rr, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic             we;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (bus.req),
        .rr  (rr),
        .en  (!full_q && !rst),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign we = |gnt;

    always_comb begin
        bus.mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                bus.mem_wdata = bus.wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Flags are computed from the post-write pointer so full never lags a write.
    assign next_bin   = wptr_bin + PTR_W'(we);
    assign next_gray  = PTR_W'(bin2gray(GW'(next_bin)));
    assign rptr_bin   = PTR_W'(gray2bin(GW'(bus.rptr_sync)));
    assign full_cmp   = {~bus.rptr_sync[PTR_W-1:PTR_W-2], bus.rptr_sync[PTR_W-3:0]};
    assign level_next = next_bin - rptr_bin;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_bin    <= '0;
            wptr_gray_q <= '0;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            wlevel_q    <= '0;
            rr          <= '0;
        end else begin
            wptr_bin    <= next_bin;
            wptr_gray_q <= next_gray;
            full_q      <= (next_gray == full_cmp);
            af_q        <= (level_next >= PTR_W'(AF_THRESH));
            wlevel_q    <= level_next;
            if (we) begin
                rr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    assign bus.gnt         = gnt;
    assign bus.mem_we      = we;
    assign bus.mem_waddr   = wptr_bin[ADDR_WIDTH-1:0];
    assign bus.wptr_gray   = wptr_gray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wlevel      = wlevel_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    fifo_wr_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .NUM_REQ(4), .AF_THRESH(56)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [6:0] g7(input logic [6:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.rptr_sync = 7'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.wdata_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.rptr_sync = 7'd0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else passed++;
            total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.mem_we); else passed++;
            total++; if (bus.mem_wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", bus.mem_wdata); else passed++;
        end
        #1;
        total++; if (bus.wptr_gray !== 7'd0) $display("FAIL reset_wptr: got %b want 0", bus.wptr_gray); else passed++;
        total++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else passed++;
        total++; if (bus.almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", bus.almost_full); else passed++;
        total++; if (bus.wlevel !== 7'd0) $display("FAIL reset_wlevel: got %0d want 0", bus.wlevel); else passed++;
        bus.req = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'b0001 << (i % 4);
            @(negedge clk);
            total++; if (bus.gnt !== exp_g) $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); else passed++;
            total++; if (bus.mem_waddr !== 6'(i)) $display("FAIL rr_waddr[%0d]: got %0d want %0d", i, bus.mem_waddr, i); else passed++;
            total++; if (bus.mem_wdata !== 8'(8'hA0 + (i % 4))) $display("FAIL rr_wdata[%0d]: got %h want %h", i, bus.mem_wdata, 8'(8'hA0 + (i % 4))); else passed++;
            tick();
        end
        bus.req = 4'b0000;
        total++; if (bus.wlevel !== 7'd8) $display("FAIL rr_wlevel: got %0d want 8", bus.wlevel); else passed++;
        total++; if (bus.wptr_gray !== g7(7'd8)) $display("FAIL rr_wptr: got %b want %b", bus.wptr_gray, g7(7'd8)); else passed++;
    endtask

    task automatic test_fill_drain();
        do_reset();
        bus.req = 4'b0001;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            total++; if (bus.gnt !== 4'b0001) $display("FAIL fill_gnt[%0d]: got %b want 0001", k, bus.gnt); else passed++;
            tick();
            total++; if (bus.almost_full !== (k >= 56)) $display("FAIL fill_af[%0d]: got %b want %b", k, bus.almost_full, (k >= 56)); else passed++;
            total++; if (bus.full !== (k == 64)) $display("FAIL fill_full[%0d]: got %b want %b", k, bus.full, (k == 64)); else passed++;
        end
        total++; if (bus.wptr_gray !== 7'b1100000) $display("FAIL fill_wptr: got %b want 1100000", bus.wptr_gray); else passed++;
        total++; if (bus.wlevel !== 7'd64) $display("FAIL fill_wlevel: got %0d want 64", bus.wlevel); else passed++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (bus.gnt !== 4'b0000) $display("FAIL fill_blocked: got %b want 0000", bus.gnt); else passed++;
            tick();
        end
        // Reader consumes one word: one slot frees up, exactly one write refills it.
        bus.rptr_sync = 7'b0000001;
        tick();
        total++; if (bus.full !== 1'b0) $display("FAIL drain_full_fall: got %b want 0", bus.full); else passed++;
        total++; if (bus.wlevel !== 7'd63) $display("FAIL drain_wlevel: got %0d want 63", bus.wlevel); else passed++;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0001) $display("FAIL drain_gnt: got %b want 0001", bus.gnt); else passed++;
        total++; if (bus.mem_waddr !== 6'd0) $display("FAIL drain_waddr: got %0d want 0", bus.mem_waddr); else passed++;
        tick();
        total++; if (bus.full !== 1'b1) $display("FAIL drain_full_rise: got %b want 1", bus.full); else passed++;
        total++; if (bus.wlevel !== 7'd64) $display("FAIL drain_wlevel2: got %0d want 64", bus.wlevel); else passed++;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0000) $display("FAIL drain_blocked: got %b want 0000", bus.gnt); else passed++;
        bus.req = 4'b0000;
        bus.rptr_sync = 7'd0;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 4'b0100;
        for (int w = 0; w < 128; w++) begin
            bus.rptr_sync = g7(7'(w));
            @(negedge clk);
            total++; if (bus.mem_we !== 1'b1) $display("FAIL wrap_we[%0d]: got %b want 1", w, bus.mem_we); else passed++;
            tick();
            total++; if (bus.wptr_gray !== g7(7'(w + 1))) $display("FAIL wrap_wptr[%0d]: got %b want %b", w, bus.wptr_gray, g7(7'(w + 1))); else passed++;
            total++; if (bus.full !== 1'b0) $display("FAIL wrap_full[%0d]: got %b want 0", w, bus.full); else passed++;
            total++; if (bus.wlevel !== 7'd1) $display("FAIL wrap_wlevel[%0d]: got %0d want 1", w, bus.wlevel); else passed++;
            if (w == 126) begin
                total++; if (bus.wptr_gray !== 7'b1000000) $display("FAIL wrap_wptr127: got %b want 1000000", bus.wptr_gray); else passed++;
            end
        end
        total++; if (bus.wptr_gray !== 7'b0000000) $display("FAIL wrap_wptr0: got %b want 0000000", bus.wptr_gray); else passed++;
        bus.req = 4'b0000;
        bus.rptr_sync = 7'd0;
        tick();
        total++; if (bus.wlevel !== 7'd0) $display("FAIL wrap_level_empty: got %0d want 0", bus.wlevel); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 4'b0110;
        for (int k = 1; k <= 29; k++) begin
            tick();
        end
        total++; if (bus.wlevel !== 7'd29) $display("FAIL mid_pre_level: got %0d want 29", bus.wlevel); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0000) $display("FAIL mid_rst_gnt: got %b want 0000", bus.gnt); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL mid_rst_we: got %b want 0", bus.mem_we); else passed++;
        total++; if (bus.mem_wdata !== 8'h00) $display("FAIL mid_rst_wdata: got %h want 00", bus.mem_wdata); else passed++;
        tick();
        rst = 1'b0;
        total++; if (bus.wptr_gray !== 7'd0) $display("FAIL mid_wptr: got %b want 0", bus.wptr_gray); else passed++;
        total++; if (bus.wlevel !== 7'd0) $display("FAIL mid_wlevel: got %0d want 0", bus.wlevel); else passed++;
        total++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0) $display("FAIL mid_flags: got %b%b want 00", bus.full, bus.almost_full); else passed++;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0010) $display("FAIL mid_first_gnt: got %b want 0010", bus.gnt); else passed++;
        total++; if (bus.mem_waddr !== 6'd0) $display("FAIL mid_waddr: got %0d want 0", bus.mem_waddr); else passed++;
        total++; if (bus.mem_wdata !== 8'hA1) $display("FAIL mid_wdata: got %h want a1", bus.mem_wdata); else passed++;
        tick();
        bus.req = 4'b0000;
    endtask

    initial begin
        bus.req = 4'b0000;
        bus.wdata_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.rptr_sync = 7'd0;
        test_reset();
        test_round_robin();
        test_fill_drain();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-side controller for the async FIFO.
- Shares the single FIFO write port between NUM_REQ producers with round-robin arbitration.
- Generates the binary and Gray write pointers.
- Derives full, almost_full and fill level from the read pointer after it has crossed into the write domain through the pointer synchronizer.
- Sits entirely in the write clock domain, between the producers and the dual-port memory.

Parameters:
- ADDR_WIDTH, 6: memory address bits. Depth = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8: width of one FIFO word.
- NUM_REQ, 4: number of producers; minimum 2.
- AF_THRESH, 56: almost_full asserts when fill level >= AF_THRESH. Legal range 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request; must hold until granted.
- wdata_in  in  NUM_REQ*DATA_WIDTH  producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot grant, combinational. The write occurs in the cycle gnt[i] is high.
- mem_we  out  1  memory write enable, equal to |gnt.
- mem_waddr  out  ADDR_WIDTH  equal to wptr_bin[ADDR_WIDTH-1:0].
- mem_wdata  out  DATA_WIDTH  data of the granted producer; 0 when there is no grant.
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchronizer.
- rptr_sync  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk.
- full  out  1  registered.
- almost_full  out  1  registered.
- wlevel  out  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH.

Behaviour:
- Reset (sampled on posedge clk while rst=1):
  - wptr_bin=0, wptr_gray=0, full=0, almost_full=0, wlevel=0.
  - Round-robin pointer rr=0.
  - gnt/mem_we/mem_wdata are 0 while rst=1.
  - A reset mid-operation discards all in-flight state in one cycle; no write occurs in the reset cycle.
- Arbitration (combinational):
  - If full=1 or req=0: gnt=0.
  - Otherwise grant the first requesting index searching rr, rr+1, ... mod NUM_REQ.
  - Exactly one grant per cycle at most.
- rr update:
  - After a grant to index i: rr <= (i+1) mod NUM_REQ.
  - With no grant: rr is unchanged.
- Pointer advance:
  - On mem_we: wptr_bin <= wptr_bin+1, mod 2**(ADDR_WIDTH+1). Wrap from all-ones to 0 is silent.
  - wptr_gray <= bin2gray(next bin).
  - Write latency: data is presented to the memory in the grant cycle; the pointer is visible on wptr_gray on the next clk edge.
- Full:
  - full <= (next_gray == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}), where next_gray is the post-update Gray pointer.
  - full therefore rises the cycle after the write that fills the last slot, and never lags behind a write.
  - full falls the cycle after rptr_sync advances.
  - full is pessimistic by the synchronizer latency; that is acceptable.
- Level and almost_full:
  - wlevel <= next_bin - gray2bin(rptr_sync), mod 2**(ADDR_WIDTH+1).
  - almost_full <= (that value >= AF_THRESH).
- Simultaneous write and rptr_sync change: both are evaluated against the same-cycle values; the result reflects both.
- rptr_sync is assumed Gray-coherent (at most one bit changes per cycle); no checking is done in this block.
- Overflow is impossible by construction: no grant while full.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parameterized by width via a width-generic implementation.
  - localparam helper for pointer width (ADDR_WIDTH+1).
- One natural sub-module: rr_arbiter.
  - Inputs: NUM_REQ req, rr pointer, enable.
  - Output: one-hot gnt plus the granted index.
  - Reused later for the read side.
- Pointer and flag logic stay in fifo_wr_ctrl.

Test Plan:
- Reset: drive rst=1 for 2 cycles with req=4'b1111 -> gnt=0, mem_we=0, wptr_gray=0, full=0, almost_full=0, wlevel=0.
- Round-robin: req=4'b1111 for 8 cycles, rptr_sync=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; mem_waddr 0..7; wlevel=8 afterward.
- Fill: req=4'b0001 continuously, rptr_sync=0:
  - almost_full rises the cycle after the 56th write.
  - full rises the cycle after the 64th write.
  - wptr_bin=7'b1000000, wptr_gray=7'b1100000, wlevel=64.
  - gnt=0 from then on.
- Drain: from full, set rptr_sync=7'b0000001 (binary 1) -> full=0 next cycle, exactly one grant, then full=1 again.
- Wrap: preload via 127 writes, matched by rptr_sync updates -> pointer goes 127 to 0 with wptr_gray 7'b1000000 to 7'b0000000; no spurious full; wlevel stays correct.
- Mid-operation reset: assert rst at write 30 with req=4'b0110 -> next cycle all outputs 0 and rr=0; the first grant after release goes to index 1.
